// File: rtl/uart_rx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART receiver.
// MMIOStruct carries the cosim trace record shared with the other MMIO devices.
// kbd_pkg holds the register map, status bit positions and receiver state codes.
// Driver tests and the RTL both use kbd_pkg, so they always agree on the map.
package MMIOStruct;

  typedef struct packed {
    logic        store;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [63:0] val;
  } MMIOPack;

endpackage

package kbd_pkg;

  // Base byte address of the keyboard/serial-input device (DATA register).
  localparam logic [63:0] KBD_BASE     = 64'h0000_0000_1000_0100;

  // Register offsets from the base address.
  localparam logic [63:0] KBD_DATA_OFS = 64'd0;
  localparam logic [63:0] KBD_STAT_OFS = 64'd8;

  // STAT register bit positions.
  localparam int STAT_NONEMPTY_BIT  = 0;
  localparam int STAT_FULL_BIT      = 1;
  localparam int STAT_OVERRUN_BIT   = 2;
  localparam int STAT_FRAME_ERR_BIT = 3;
  localparam int STAT_COUNT_LSB     = 8;

  // DATA register: bit 8 flags that the low byte holds a received character.
  localparam int DATA_VALID_BIT = 8;

  // Receiver frame-sampler states.
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Format the STAT register word from its individual fields.
  function automatic logic [63:0] stat_word(input logic [7:0] count,
                                            input logic       frame_err,
                                            input logic       overrun,
                                            input logic       full,
                                            input logic       nonempty);
    logic [63:0] w;
    w = 64'd0;
    w[STAT_COUNT_LSB +: 8]   = count;
    w[STAT_FRAME_ERR_BIT]    = frame_err;
    w[STAT_OVERRUN_BIT]      = overrun;
    w[STAT_FULL_BIT]         = full;
    w[STAT_NONEMPTY_BIT]     = nonempty;
    return w;
  endfunction

  // Format the DATA register word; an empty FIFO reads as all zeros.
  function automatic logic [63:0] data_word(input logic       nonempty,
                                            input logic [7:0] head);
    logic [63:0] w;
    w = 64'd0;
    if (nonempty) begin
      w[DATA_VALID_BIT] = 1'b1;
      w[7:0]            = head;
    end else begin
      w = 64'd0;
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_mmio_sync_fifo.sv
// Small synchronous FIFO holding received bytes.
// A push while full is still accepted when a pop happens in the same cycle,
// because the pop frees the slot the push lands in. Status outputs are flops.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       nonempty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & nonempty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Track read/write pointers, occupancy and the registered full/nonempty flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      nonempty <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10: begin
          count    <= count + CW'(1);
          nonempty <= 1'b1;
          full     <= (count == CW'(DEPTH - 1));
        end
        2'b01: begin
          count    <= count - CW'(1);
          nonempty <= (count != CW'(1));
          full     <= 1'b0;
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

  // Write the incoming byte into the tail slot; storage needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped serial input device: receives 8N1 UART frames on rx_i into a
// small FIFO; the CPU polls STAT and pops bytes by reading DATA.
module uart_rx_mmio
  import kbd_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR    = KBD_BASE,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [63:0]          address_i,
  input  logic [63:0]          indata_i,
  input  logic                 wen_i,
  input  logic                 ren_i,
  input  logic [7:0]           mask_i,
  input  logic                 rx_i,
  output logic                 valid_o,
  output logic [63:0]          outdata_o,
  output MMIOStruct::MMIOPack  cosim_mmio,
  output logic                 irq_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [63:0]      DATA_ADDR   = BASE_ADDR + KBD_DATA_OFS;
  localparam logic [63:0]      STAT_ADDR   = BASE_ADDR + KBD_STAT_OFS;

  logic             rx_meta;
  logic             rx_s;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       sh;
  logic             stop_tick;
  logic             rx_push;
  logic             rx_ferr;

  logic             overrun;
  logic             frame_err;
  logic             overrun_set;
  logic             rd_data;
  logic             rd_stat;
  logic             wr_stat;
  logic             pop;
  logic [63:0]      rdata;

  logic [7:0]       head;
  logic             full;
  logic             nonempty;
  logic [FCW-1:0]   fifo_count;
  logic             unused_bits;

  // Two-flop synchroniser for the asynchronous pin; both stages idle high.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // Frame sampler: find the start edge, sample each bit at its centre.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= RX_IDLE;
      cnt   <= '0;
      idx   <= 3'd0;
      sh    <= 8'd0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            state <= RX_START;
            cnt   <= HALF_RELOAD;
          end
        end
        RX_START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              state <= RX_DATA;
              cnt   <= BIT_RELOAD;
              idx   <= 3'd0;
            end else begin
              // Start bit did not last to its midpoint: treat as a glitch.
              state <= RX_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == '0) begin
            sh[idx] <= rx_s;
            cnt     <= BIT_RELOAD;
            if (idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt == '0) begin
            state <= RX_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= RX_IDLE;
        end
      endcase
    end
  end

  assign stop_tick = (state == RX_STOP) && (cnt == '0);
  assign rx_push   = stop_tick & rx_s;
  assign rx_ferr   = stop_tick & ~rx_s;

  assign rd_data     = ren_i && (address_i == DATA_ADDR);
  assign rd_stat     = ren_i && (address_i == STAT_ADDR);
  assign wr_stat     = wen_i && mask_i[0] && (address_i == STAT_ADDR);
  assign pop         = rd_data & nonempty;
  assign overrun_set = rx_push & full & ~pop;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (rx_push),
    .pop      (pop),
    .wdata    (sh),
    .rdata    (head),
    .full     (full),
    .nonempty (nonempty),
    .count    (fifo_count)
  );

  // Sticky error flags: write-one-to-clear, a same-cycle set beats the clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= overrun_set |
                   (overrun & ~(wr_stat & indata_i[STAT_OVERRUN_BIT]));
      frame_err <= rx_ferr |
                   (frame_err & ~(wr_stat & indata_i[STAT_FRAME_ERR_BIT]));
    end
  end

  // Read map; anything other than a read of DATA or STAT returns zero.
  always_comb begin
    rdata = 64'd0;
    if (rd_data) begin
      rdata = data_word(nonempty, head);
    end else if (rd_stat) begin
      rdata = stat_word(8'(fifo_count), frame_err, overrun, full, nonempty);
    end else begin
      rdata = 64'd0;
    end
  end

  assign outdata_o        = rdata;
  assign valid_o          = 1'b1;
  assign irq_o            = nonempty;

  assign cosim_mmio.store = wen_i;
  assign cosim_mmio.addr  = address_i;
  assign cosim_mmio.len   = 8'd8;
  assign cosim_mmio.val   = wen_i ? indata_i : rdata;

  // Only the flag-clear bits of a STAT write and mask bit 0 matter here.
  assign unused_bits = ^{mask_i[7:1], indata_i[63:4], indata_i[1:0]};

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio: serialises frames onto rx, keeps a
// byte-queue model of the device, and compares every cycle plus literal reads.
module tb_uart_rx_mmio;
  import kbd_pkg::*;

  localparam int          CPB      = 16;
  localparam int          DEPTH    = 8;
  localparam logic [63:0] BASE     = KBD_BASE;
  localparam logic [63:0] STAT_A   = KBD_BASE + 64'd8;
  // Start edge reaches the sampler after 2 sync flops + 1 detect cycle; the
  // stop bit is then sampled half a bit plus nine full bits later.
  localparam int          PUSH_LAT = 3 + CPB / 2 + 9 * CPB;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [63:0]         address = 64'd0;
  logic [63:0]         indata = 64'd0;
  logic                wen = 1'b0;
  logic                ren = 1'b0;
  logic [7:0]          mask = 8'd0;
  logic                rx = 1'b1;
  logic                valid;
  logic [63:0]         outdata;
  MMIOStruct::MMIOPack cosim;
  logic                irq;

  always #5 clk = ~clk;

  uart_rx_mmio #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .address_i  (address),
    .indata_i   (indata),
    .wen_i      (wen),
    .ren_i      (ren),
    .mask_i     (mask),
    .rx_i       (rx),
    .valid_o    (valid),
    .outdata_o  (outdata),
    .cosim_mmio (cosim),
    .irq_o      (irq)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         cmp_en = 1'b0;
  logic [7:0] mq[$];
  bit         m_ovr = 1'b0;
  bit         m_ferr = 1'b0;
  logic       line_q[$];
  int         evt_kind[int];
  logic [7:0] evt_byte[int];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model reaction to one clock edge, using the inputs held during that cycle.
  task automatic model_edge();
    bit pop;
    bit full;
    bit s_ovr;
    bit s_ferr;
    if (!rstn) begin
      mq.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      evt_kind.delete();
      evt_byte.delete();
      return;
    end
    pop    = ren && (address == BASE) && (mq.size() > 0);
    full   = (mq.size() == DEPTH);
    s_ovr  = 1'b0;
    s_ferr = 1'b0;
    if (pop) void'(mq.pop_front());
    if (evt_kind.exists(cyc)) begin
      if (evt_kind[cyc] == 1) begin
        if (!full || pop) mq.push_back(evt_byte[cyc]);
        else s_ovr = 1'b1;
      end else begin
        s_ferr = 1'b1;
      end
      evt_kind.delete(cyc);
      evt_byte.delete(cyc);
    end
    if (wen && mask[0] && (address == STAT_A)) begin
      if (indata[2]) m_ovr = 1'b0;
      if (indata[3]) m_ferr = 1'b0;
    end
    if (s_ovr) m_ovr = 1'b1;
    if (s_ferr) m_ferr = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    rx = (line_q.size() > 0) ? line_q.pop_front() : 1'b1;
  endtask

  function automatic logic [63:0] exp_out();
    logic [63:0] w;
    w = 64'd0;
    if (ren && address == BASE && mq.size() > 0) begin
      w[8]   = 1'b1;
      w[7:0] = mq[0];
    end else if (ren && address == STAT_A) begin
      w[15:8] = 8'(mq.size());
      w[3]    = m_ferr;
      w[2]    = m_ovr;
      w[1]    = (mq.size() == DEPTH);
      w[0]    = (mq.size() != 0);
    end
    return w;
  endfunction

  // Compare every DUT output with the model once per cycle, mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [63:0] e;
      e = exp_out();
      chk("outdata", outdata, e);
      chk("irq", {63'd0, irq}, {63'd0, (mq.size() != 0)});
      chk("valid", {63'd0, valid}, 64'd1);
      chk("cosim_store", {63'd0, cosim.store}, {63'd0, wen});
      chk("cosim_addr", cosim.addr, address);
      chk("cosim_len", {56'd0, cosim.len}, 64'd8);
      chk("cosim_val", cosim.val, wen ? indata : e);
    end
  end

  // Queue one 8N1 frame on the line; ev returns the edge its stop bit is judged.
  task automatic send_frame(input logic [7:0] b, input bit ok, output int ev);
    int start;
    start = cyc + 1 + line_q.size();
    for (int i = 0; i < CPB; i++) line_q.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < CPB; i++) line_q.push_back(b[k]);
    for (int i = 0; i < CPB; i++) line_q.push_back(ok);
    ev = start + PUSH_LAT;
    evt_kind[ev] = ok ? 1 : 2;
    evt_byte[ev] = b;
  endtask

  task automatic idle_line(input int n);
    for (int i = 0; i < n; i++) line_q.push_back(1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    ren = 1'b0;
    wen = 1'b0;
    while (line_q.size() != 0 || evt_kind.num() != 0) begin
      tick();
      n++;
      if (n > 20000) begin
        chk("drain_timeout", 64'd1, 64'd0);
        break;
      end
    end
    tick();
  endtask

  task automatic rd(input logic [63:0] a, input logic [63:0] exp, input string nm);
    ren = 1'b1;
    wen = 1'b0;
    address = a;
    #1;
    chk(nm, outdata, exp);
    tick();
    ren = 1'b0;
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d);
    wen = 1'b1;
    ren = 1'b0;
    address = a;
    indata = d;
    mask = 8'hFF;
    tick();
    wen = 1'b0;
    mask = 8'h00;
  endtask

  task automatic rand_mmio(input int rp);
    int r;
    r = $urandom_range(0, 99);
    ren = 1'b0;
    wen = 1'b0;
    mask = 8'h00;
    indata = {$urandom(), $urandom()};
    if (r < rp) begin
      ren = 1'b1;
      address = BASE;
    end else if (r < rp + 5) begin
      ren = 1'b1;
      address = STAT_A;
    end else if (r < rp + 7) begin
      wen = 1'b1;
      address = ($urandom_range(0, 1) == 1) ? STAT_A : BASE;
      mask = 8'($urandom());
    end else if (r < rp + 9) begin
      ren = 1'b1;
      address = BASE + 64'd16;
    end
  endtask

  initial begin
    int ev;
    logic [7:0] ov_b[9];
    int rps[4];
    ov_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66, 8'h77, 8'h88, 8'h99};
    rps  = '{0, 1, 5, 20};

    // Reset
    tick();
    cmp_en = 1'b1;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    rd(STAT_A, 64'h0, "reset_stat");
    rd(BASE, 64'h0, "reset_data");
    chk("reset_irq", {63'd0, irq}, 64'd0);

    // Single frame 0x41
    send_frame(8'h41, 1'b1, ev);
    drain();
    rd(STAT_A, 64'h0101, "one_stat");
    chk("one_irq", {63'd0, irq}, 64'd1);
    rd(BASE, 64'h141, "one_data");
    rd(STAT_A, 64'h0, "one_stat_after");
    rd(BASE, 64'h0, "one_data_empty");

    // Back-to-back frames keep order
    send_frame(8'h55, 1'b1, ev);
    send_frame(8'hAA, 1'b1, ev);
    send_frame(8'h0F, 1'b1, ev);
    drain();
    rd(STAT_A, 64'h0301, "b2b_stat");
    rd(BASE, 64'h155, "b2b_d0");
    rd(BASE, 64'h1AA, "b2b_d1");
    rd(BASE, 64'h10F, "b2b_d2");

    // Overflow: DEPTH+1 frames with no reads
    for (int i = 0; i < 9; i++) send_frame(ov_b[i], 1'b1, ev);
    drain();
    rd(STAT_A, 64'h0807, "ovf_stat");
    for (int i = 0; i < 8; i++) rd(BASE, {55'd0, 1'b1, ov_b[i]}, "ovf_data");
    rd(STAT_A, 64'h0004, "ovf_sticky");
    wr(STAT_A, 64'h4);
    rd(STAT_A, 64'h0, "ovf_cleared");

    // Framing error keeps count, W1C clears it
    send_frame(8'h12, 1'b1, ev);
    send_frame(8'h99, 1'b0, ev);
    idle_line(2 * CPB);
    drain();
    rd(STAT_A, 64'h0109, "ferr_stat");
    rd(BASE, 64'h112, "ferr_data");
    wr(STAT_A, 64'h8);
    rd(STAT_A, 64'h0, "ferr_cleared");

    // Short low glitch is rejected
    for (int i = 0; i < CPB / 2 - 2; i++) line_q.push_back(1'b0);
    idle_line(3 * CPB);
    drain();
    rd(STAT_A, 64'h0, "glitch_stat");

    // Pop coinciding with the push into a full FIFO
    for (int i = 0; i < 8; i++) send_frame(ov_b[i] ^ 8'hF0, 1'b1, ev);
    drain();
    rd(STAT_A, 64'h0803, "full_stat");
    send_frame(8'hC3, 1'b1, ev);
    while (cyc < ev - 1) tick();
    ren = 1'b1;
    address = BASE;
    #1;
    chk("coinc_pop", outdata, {55'd0, 1'b1, ov_b[0] ^ 8'hF0});
    tick();
    ren = 1'b0;
    drain();
    rd(STAT_A, 64'h0803, "coinc_stat");

    // Reset in the middle of a frame
    send_frame(8'h3C, 1'b1, ev);
    for (int i = 0; i < 60; i++) tick();
    rstn = 1'b0;
    line_q.delete();
    rx = 1'b1;
    tick();
    tick();
    rstn = 1'b1;
    idle_line(PUSH_LAT + CPB);
    drain();
    rd(STAT_A, 64'h0, "midrst_stat");
    chk("midrst_irq", {63'd0, irq}, 64'd0);

    // Randomised traffic
    for (int f = 0; f < 40; f++) begin
      int rp;
      bit ok;
      rp = rps[$urandom_range(0, 3)];
      ok = ($urandom_range(0, 9) != 0);
      send_frame(8'($urandom()), ok, ev);
      if (!ok) idle_line(2 * CPB);
      else if ($urandom_range(0, 1) == 1) idle_line($urandom_range(0, 20));
      while (line_q.size() > 0) begin
        rand_mmio(rp);
        tick();
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
